// File: rtl/cnn_cdc_pkg.sv
// rtl/cnn_cdc_pkg.sv - shared state encoding and parameter defaults for the go/done responder
// Watchdog default width exists only when GO_RESP_TIMEOUT_EN is defined.
package cnn_cdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } go_resp_state_e;

    localparam int PEND_W_DEF = 4;
`ifdef GO_RESP_TIMEOUT_EN
    localparam int TIMEOUT_W_DEF = 16;
`endif

endpackage

// File: rtl/go_resp_wdog.sv
// rtl/go_resp_wdog.sv - job watchdog: clearable up-counter with a terminal-count pulse
module go_resp_wdog #(
    parameter int           W     = 16,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the last permitted cycle so the owner leaves on the following edge.
    assign tc_o = en_i && (cnt == LIMIT - 1'b1);

endmodule

// File: rtl/go_done_responder.sv
// rtl/go_done_responder.sv - engine-side go/done toggle responder; GO_RESP_TIMEOUT_EN adds the job watchdog
module go_done_responder
    import cnn_cdc_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF
`ifdef GO_RESP_TIMEOUT_EN
   ,parameter int                   TIMEOUT_W = TIMEOUT_W_DEF,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = '1
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              go_i,
    input  logic              eng_busy_i,
    output logic              eng_start_o,
    input  logic              eng_done_i,
    output logic              done_flip_o,
    output logic              done_o,
    output logic [PEND_W-1:0] pending_o,
    output logic              err_ovf_o,
    output logic              err_tmo_o,
    output logic [1:0]        state_o
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    go_resp_state_e    state;
    go_resp_state_e    state_nx;
    logic [PEND_W-1:0] pending;
    logic              in_done;
    logic              go_acc;
    logic              tmo_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pending != '0 && !eng_busy_i) state_nx = START;
            START:   state_nx = RUN;
            RUN:     if (eng_done_i || tmo_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_done = (state == DONE);
    // A full counter can still take a request in the cycle that retires one.
    assign go_acc  = go_i && (pending != PEND_MAX || in_done);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending     <= '0;
            err_ovf_o   <= 1'b0;
            eng_start_o <= 1'b0;
            done_flip_o <= 1'b0;
        end else begin
            if (go_acc && !in_done) begin
                pending <= pending + 1'b1;
            end else if (!go_i && in_done) begin
                pending <= pending - 1'b1;
            end
            if (go_i && !go_acc) begin
                err_ovf_o <= 1'b1;
            end
            eng_start_o <= (state == START);
            if (state == RUN && state_nx == DONE) begin
                done_flip_o <= ~done_flip_o;
            end
        end
    end

`ifdef GO_RESP_TIMEOUT_EN
    go_resp_wdog #(
        .W     (TIMEOUT_W),
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (state == START),
        .en_i    (state == RUN),
        .tc_o    (tmo_hit)
    );

    // A genuine completion on the terminal cycle is not counted as a timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_tmo_o <= 1'b0;
        end else if (tmo_hit && !eng_done_i) begin
            err_tmo_o <= 1'b1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign err_tmo_o = 1'b0;
`endif

    assign done_o    = in_done;
    assign pending_o = pending;
    assign state_o   = state;

endmodule
